// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the host-link response frame serializer.
package frame_pkg;

    localparam logic [7:0] SOF1_BYTE     = 8'hAA;
    localparam logic [7:0] SOF2_BYTE     = 8'h55;
    localparam logic [7:0] CMD_HEARTBEAT = 8'hFF;
    localparam logic [7:0] CMD_PWM       = 8'hFE;
    localparam int         CHK_W         = 8;

    // state | meaning (byte held in the output register)
    // S_IDLE    | no frame in progress
    // S_SOF1    | AA presented
    // S_SOF2    | 55 presented
    // S_CMD     | command byte presented
    // S_LENH    | length high byte presented
    // S_LENL    | length low byte presented, zero-length frame
    // S_PAYLOAD | length low or payload bytes presented / being fetched
    // S_CHK     | checksum pending or presented, waiting for acceptance
    typedef enum logic [2:0] {
        S_IDLE, S_SOF1, S_SOF2, S_CMD, S_LENH, S_LENL, S_PAYLOAD, S_CHK
    } state_t;

endpackage

// File: rtl/frame_tx.sv
// Response-frame serializer: AA 55 CMD LEN_H LEN_L <payload> CHK, one byte per cycle.
// Optional payload-stall timeout is built when FRAME_TX_TIMEOUT_EN is defined.
module frame_tx
    import frame_pkg::*;
#(
    parameter int MAX_LEN = 64
`ifdef FRAME_TX_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [7:0]  tx_cmd,
    input  logic [15:0] tx_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  usb_data_out,
    output logic        usb_valid_out,
    input  logic        usb_ready_in,
    output logic        busy,
    output logic        done,
    output logic        len_err,
    output logic        timeout_err
);

    state_t             state;
    logic [7:0]         cmd_q;
    logic [15:0]        len_q;
    logic [15:0]        remaining;
    logic [CHK_W-1:0]   checksum;
    logic               chk_loaded;
    logic               load_en;
    logic               accept;
    logic               pl_take;
    logic               pay_load;
    logic [7:0]         pay_byte;
    logic               timed_out;

    assign load_en  = !usb_valid_out || usb_ready_in;
    assign accept   = (state == S_IDLE) && tx_start && (tx_len <= 16'(MAX_LEN));
    assign pl_ready = (state == S_PAYLOAD) && load_en && !timed_out;
    assign pl_take  = pl_valid && pl_ready;
    // After a stall timeout the rest of the payload is padded with zeros.
    assign pay_load = pl_take || ((state == S_PAYLOAD) && timed_out && load_en);
    assign pay_byte = timed_out ? 8'h00 : pl_data;

`ifdef FRAME_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] stall_cnt;

    assign timed_out = timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= TO_RELOAD;
            timeout_err <= 1'b0;
        end else if (accept) begin
            stall_cnt   <= TO_RELOAD;
            timeout_err <= 1'b0;
        end else if ((state == S_PAYLOAD) && !timeout_err) begin
            if (pl_take)
                stall_cnt <= TO_RELOAD;
            else if (stall_cnt == '0)
                timeout_err <= 1'b1;
            else
                stall_cnt <= stall_cnt - 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cmd_q         <= 8'h00;
            len_q         <= 16'h0000;
            remaining     <= 16'h0000;
            checksum      <= '0;
            chk_loaded    <= 1'b0;
            usb_data_out  <= 8'h00;
            usb_valid_out <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_q         <= tx_cmd;
                        len_q         <= tx_len;
                        remaining     <= tx_len;
                        checksum      <= tx_cmd + tx_len[15:8] + tx_len[7:0];
                        chk_loaded    <= 1'b0;
                        busy          <= 1'b1;
                        usb_data_out  <= SOF1_BYTE;
                        usb_valid_out <= 1'b1;
                        state         <= S_SOF1;
                    end else if (tx_start) begin
                        len_err <= 1'b1;
                    end
                end
                S_SOF1: if (load_en) begin
                    usb_data_out <= SOF2_BYTE;
                    state        <= S_SOF2;
                end
                S_SOF2: if (load_en) begin
                    usb_data_out <= cmd_q;
                    state        <= S_CMD;
                end
                S_CMD: if (load_en) begin
                    usb_data_out <= len_q[15:8];
                    state        <= S_LENH;
                end
                S_LENH: if (load_en) begin
                    usb_data_out <= len_q[7:0];
                    state        <= (len_q == 16'h0000) ? S_LENL : S_PAYLOAD;
                end
                S_LENL: if (load_en) begin
                    usb_data_out <= checksum;
                    chk_loaded   <= 1'b1;
                    state        <= S_CHK;
                end
                S_PAYLOAD: begin
                    if (pay_load) begin
                        usb_data_out  <= pay_byte;
                        usb_valid_out <= 1'b1;
                        checksum      <= checksum + pay_byte;
                        remaining     <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= S_CHK;
                    end else if (load_en) begin
                        usb_valid_out <= 1'b0;
                    end
                end
                S_CHK: begin
                    if (!chk_loaded) begin
                        if (load_en) begin
                            usb_data_out  <= checksum;
                            usb_valid_out <= 1'b1;
                            chk_loaded    <= 1'b1;
                        end
                    end else if (usb_ready_in) begin
                        usb_valid_out <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: expected frame bytes are queued at issue time and
// popped by an independent monitor on every downstream handshake.
module tb_frame_tx;
    import frame_pkg::*;

    localparam int MAX_LEN = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_start;
    logic [7:0]  tx_cmd;
    logic [15:0] tx_len;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  usb_data_out;
    logic        usb_valid_out;
    logic        usb_ready_in;
    logic        busy;
    logic        done;
    logic        len_err;
    logic        timeout_err;

    frame_tx #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_start(tx_start), .tx_cmd(tx_cmd), .tx_len(tx_len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .usb_data_out(usb_data_out), .usb_valid_out(usb_valid_out), .usb_ready_in(usb_ready_in),
        .busy(busy), .done(done), .len_err(len_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    bit         last_q[$];
    int         hs_cyc[$];
    int         ready_pct = 100;
    int         cyc = 0;
    int         done_cnt = 0;
    bit         pend_done = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        usb_ready_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            usb_ready_in = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: scoreboard pop, done timing, hold-while-stalled, pl_ready when idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_done  = 0;
            prev_stall = 0;
        end else begin
            check("done", 32'(done), 32'(pend_done));
            if (pend_done) check("busy_at_done", 32'(busy), 0);
            if (done) done_cnt++;
            pend_done = 0;
            if (prev_stall) begin
                check("hold_valid", 32'(usb_valid_out), 1);
                check("hold_data", 32'(usb_data_out), 32'(prev_data));
            end
            if (!busy) check("pl_ready_idle", 32'(pl_ready), 0);
            if (usb_valid_out && usb_ready_in) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none", usb_data_out);
                end else begin
                    check("frame_byte", 32'(usb_data_out), 32'(exp_q.pop_front()));
                    if (last_q.pop_front()) pend_done = 1;
                end
            end
            prev_stall = usb_valid_out && !usb_ready_in;
            prev_data  = usb_data_out;
        end
    end

    task automatic push_exp(input logic [7:0] b, input bit last);
        exp_q.push_back(b);
        last_q.push_back(last);
    endtask

    // reset_after: assert reset after that many payload handshakes (-1: never).
    // stall_after: stop offering payload after that many bytes and expect zero fill (-1: never).
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] pay[$], input int pv_pct,
                             input int reset_after, input bit poke, input int stall_after);
        int          n;
        int          idx;
        int          budget;
        int          start_done;
        int          last_hs;
        logic [15:0] len16;
        logic [7:0]  sum;
        logic [7:0]  b;
        n      = pay.size();
        len16  = 16'(n);
        idx    = 0;
        budget = 0;
        last_hs = cyc;
        while (busy && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle actual=busy required=idle");
        end
        sum = cmd + len16[15:8] + len16[7:0];
        push_exp(SOF1_BYTE, 0);
        push_exp(SOF2_BYTE, 0);
        push_exp(cmd, 0);
        push_exp(len16[15:8], 0);
        push_exp(len16[7:0], 0);
        for (int i = 0; i < n; i++) begin
            b = (stall_after >= 0 && i >= stall_after) ? 8'h00 : pay[i];
            sum = sum + b;
            push_exp(b, 0);
        end
        push_exp(sum, 1);
        start_done = done_cnt;
        pl_valid = 1'b0;
        tx_start = 1'b1;
        tx_cmd   = cmd;
        tx_len   = len16;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_cmd   = 8'($urandom);
        check("start_busy", 32'(busy), 1);
        check("start_valid", 32'(usb_valid_out), 1);
        check("start_aa", 32'(usb_data_out), 32'(SOF1_BYTE));
`ifdef FRAME_TX_TIMEOUT_EN
        check("timeout_cleared", 32'(timeout_err), 0);
`endif
        budget = 0;
        while (idx < n && budget < 3000) begin
            if (stall_after >= 0 && idx >= stall_after) pl_valid = 1'b0;
            else pl_valid = ($urandom_range(0, 99) < pv_pct);
            pl_data = pl_valid ? pay[idx] : 8'($urandom);
            if (poke && idx == 1) begin
                tx_start = 1'b1;
                tx_cmd   = 8'h11;
                tx_len   = 16'd100;
            end
            @(negedge clk);
            if (pl_valid && pl_ready) begin
                idx++;
                last_hs = cyc;
            end
            if (stall_after >= 0 && timeout_err) begin
                check("timeout_latency", 32'(cyc - last_hs), 1000);
                pl_valid = 1'b1;
                pl_data  = 8'h77;
                #1;
                check("pl_ready_after_timeout", 32'(pl_ready), 0);
                pl_valid = 1'b0;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            tx_start = 1'b0;
            budget++;
            if (reset_after >= 0 && idx == reset_after) begin
                rst_n = 1'b0;
                exp_q.delete();
                last_q.delete();
                #1;
                check("rst_valid", 32'(usb_valid_out), 0);
                check("rst_data", 32'(usb_data_out), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_pl_ready", 32'(pl_ready), 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                pl_valid = 1'b0;
                return;
            end
        end
        tx_start = 1'b0;
        pl_valid = 1'b0;
        budget = 0;
        while ((exp_q.size() > 0 || done_cnt == start_done) && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (done_cnt == start_done) begin
            checks++;
            failures++;
            $display("FAIL frame_end actual=left%0d required=done", exp_q.size());
        end
    endtask

    logic [7:0] pay[$];
    logic [7:0] pwm[$];

    initial begin
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_cmd   = 8'h00;
        tx_len   = 16'h0000;
        pl_data  = 8'h00;
        pl_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(usb_valid_out), 0);
        check("reset_data", 32'(usb_data_out), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_len_err", 32'(len_err), 0);
        check("reset_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Heartbeat at full throughput: six bytes on consecutive cycles.
        ready_pct = 100;
        @(posedge clk);
        #1;
        hs_cyc.delete();
        pay.delete();
        run_frame(CMD_HEARTBEAT, pay, 100, -1, 0, -1);
        check("hb_bytes", 32'(hs_cyc.size()), 6);
        if (hs_cyc.size() == 6) check("hb_consecutive", 32'(hs_cyc[5] - hs_cyc[0]), 5);

        pwm = '{8'h01, 8'hEA, 8'h60, 8'h75, 8'h30};
        run_frame(CMD_PWM, pwm, 100, -1, 0, -1);

        ready_pct = 50;
        run_frame(CMD_PWM, pwm, 100, -1, 0, -1);
        run_frame(CMD_PWM, pwm, 60, -1, 1, -1);

        // Oversize request is rejected with a single len_err pulse.
        ready_pct = 100;
        tx_start = 1'b1;
        tx_cmd   = 8'h42;
        tx_len   = 16'(MAX_LEN + 1);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        check("len_err_pulse", 32'(len_err), 1);
        check("len_err_no_valid", 32'(usb_valid_out), 0);
        check("len_err_not_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        check("len_err_clear", 32'(len_err), 0);
        check("len_err_still_idle", 32'(usb_valid_out), 0);

        pay.delete();
        for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'($urandom));
        run_frame(8'h5A, pay, 80, -1, 0, -1);

        run_frame(CMD_PWM, pwm, 100, 3, 0, -1);
        pay.delete();
        run_frame(CMD_HEARTBEAT, pay, 100, -1, 0, -1);

        for (int f = 0; f < 6; f++) begin
            ready_pct = $urandom_range(30, 100);
            pay.delete();
            for (int i = 0; i < int'($urandom_range(0, MAX_LEN)); i++) pay.push_back(8'($urandom));
            run_frame(8'($urandom), pay, $urandom_range(30, 100), -1, 0, -1);
        end

`ifdef FRAME_TX_TIMEOUT_EN
        ready_pct = 100;
        run_frame(CMD_PWM, pwm, 100, -1, 0, 2);
        check("timeout_sticky", 32'(timeout_err), 1);
        pay.delete();
        run_frame(CMD_HEARTBEAT, pay, 100, -1, 0, -1);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
